// File: rtl/scsa_pkg.sv
// rtl/scsa_pkg.sv - shared types and helpers for the SCSA window sequencer
//
// Purpose: window width, sequencer state encoding and the speculative
//          carry helper used to predict each window's carry-in.
// Ports:   none (package).
// Options: SCSA_ERR_DETECT_EN is consumed by scsa_window_sequencer, not here.
package scsa_pkg;

  localparam int WIN_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Carry-out of a window add with no carry-in; used as the guess for the
  // next window's carry-in.
  function automatic logic spec_carry(input logic [WIN_W-1:0] aw,
                                      input logic [WIN_W-1:0] bw);
    logic [WIN_W:0] t;
    t = {1'b0, aw} + {1'b0, bw};
    return t[WIN_W];
  endfunction

endpackage

// File: rtl/sum_block.sv
// rtl/sum_block.sv - 4-bit window adder stage of the SCSA
//
// Purpose: adds one operand window plus a carry-in.
// Ports:
//   A_i      in  4  operand A window
//   B_i      in  4  operand B window
//   Co_iprev in  1  carry-in (speculative in the SCSA)
//   S_i      out 4  window sum
//   Co_i     out 1  window carry-out
module sum_block
  import scsa_pkg::*;
(
  input  logic [WIN_W-1:0] A_i,
  input  logic [WIN_W-1:0] B_i,
  input  logic             Co_iprev,
  output logic [WIN_W-1:0] S_i,
  output logic             Co_i
);

  logic [WIN_W:0] full;

  assign full = {1'b0, A_i} + {1'b0, B_i} + {{WIN_W{1'b0}}, Co_iprev};
  assign S_i  = full[WIN_W-1:0];
  assign Co_i = full[WIN_W];

endmodule

// File: rtl/scsa_window_sequencer.sv
// rtl/scsa_window_sequencer.sv - time-multiplexed SCSA front end
//
// Purpose: accepts an operand pair, walks one 4-bit window per cycle through
//          a single shared sum_block using a speculative carry-in per window,
//          and returns the assembled approximate sum.
// Ports:
//   clk       in  1      clock, rising edge
//   rst_n     in  1      asynchronous active-low reset
//   in_valid  in  1      operand pair valid
//   in_ready  out 1      sequencer idle and able to accept
//   a, b      in  WIDTH  operands
//   out_valid out 1      result valid
//   out_ready in  1      downstream accepts the result
//   sum       out WIDTH  approximate sum
//   cout      out 1      carry-out of the top window
//   busy      out 1      high in RUN or DONE
//   err       out 1      speculation error flag (only with SCSA_ERR_DETECT_EN)
// Options: `define SCSA_ERR_DETECT_EN adds exact-carry tracking and the err port.
module scsa_window_sequencer
  import scsa_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef SCSA_ERR_DETECT_EN
  ,
  output logic             err
`endif
);

  localparam int NWIN = WIDTH / WIN_W;
  localparam int KW   = (NWIN > 1) ? $clog2(NWIN) : 1;

  state_e           state_q, state_d;
  logic [KW-1:0]    k_q, k_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic             cout_q, cout_d;

  logic [KW+1:0]    win_lsb;
  logic [WIN_W-1:0] aw, bw, ap, bp, s_win;
  logic             spec_c, co_win, last_win;

  // Bit offset of the current window (k * 4).
  assign win_lsb  = {k_q, 2'b00};
  assign aw       = WIN_W'(a_q >> win_lsb);
  assign bw       = WIN_W'(b_q >> win_lsb);
  // Window below the current one; padding with a zero window makes k=0 see
  // 0+0, so its speculative carry is 0 without a special case.
  assign ap       = WIN_W'({a_q, {WIN_W{1'b0}}} >> win_lsb);
  assign bp       = WIN_W'({b_q, {WIN_W{1'b0}}} >> win_lsb);
  assign spec_c   = spec_carry(ap, bp);
  assign last_win = (k_q == KW'(NWIN - 1));

  sum_block u_sum_block (
    .A_i      (aw),
    .B_i      (bw),
    .Co_iprev (spec_c),
    .S_i      (s_win),
    .Co_i     (co_win)
  );

`ifdef SCSA_ERR_DETECT_EN
  logic           err_q, err_d;
  logic           cex_q, cex_d;
  logic [WIN_W:0] exact_sum;

  // True ripple add of the current window, carried from the exact chain.
  assign exact_sum = {1'b0, aw} + {1'b0, bw} + {{WIN_W{1'b0}}, cex_q};
  assign err       = err_q;
`endif

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
`ifdef SCSA_ERR_DETECT_EN
    err_d   = err_q;
    cex_d   = cex_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          sum_d   = '0;
          k_d     = '0;
`ifdef SCSA_ERR_DETECT_EN
          err_d   = 1'b0;
          cex_d   = 1'b0;
`endif
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d = (sum_q & ~(WIDTH'({WIN_W{1'b1}}) << win_lsb))
              | (WIDTH'(s_win) << win_lsb);
`ifdef SCSA_ERR_DETECT_EN
        err_d = err_q | (spec_c != cex_q)
              | (last_win && (exact_sum[WIN_W] != co_win));
        cex_d = exact_sum[WIN_W];
`endif
        if (last_win) begin
          cout_d  = co_win;
          state_d = DONE;
        end else begin
          k_d = k_q + KW'(1);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      k_q     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SCSA_ERR_DETECT_EN
      err_q   <= 1'b0;
      cex_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef SCSA_ERR_DETECT_EN
      err_q   <= err_d;
      cex_q   <= cex_d;
`endif
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;

endmodule

// File: doc/scsa_window_sequencer.md
Name: scsa_window_sequencer

Overview:
Time-multiplexed front end for the speculative carry-select adder (SCSA).
- Accepts a WIDTH-bit operand pair over a valid/ready handshake.
- Each cycle, slices one 4-bit window, computes that window's speculative carry-in, and drives one shared sum_block stage.
- Collects the per-window sums and presents the assembled approximate result downstream on valid/ready.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and at least 8.
NWIN, WIDTH/4, window count; derived only, never overridden.

Ports:
clk  in  1  single clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand pair valid.
in_ready  out  1  sequencer can accept an operand pair.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
out_valid  out  1  result valid.
out_ready  in  1  downstream accepts the result.
sum  out  WIDTH  approximate SCSA sum.
cout  out  1  carry-out of the top window.
busy  out  1  high in RUN or DONE.
err  out  1  speculation error flag; present only with SCSA_ERR_DETECT_EN.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset is rst_n, asynchronous and active-low.
- Reset values: in_ready=1 once rst_n deasserts; out_valid=0, sum=0, cout=0, busy=0, err=0; window index=0; state=IDLE.
- State machine has three states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, register a and b, clear the sum register, set k=0, go to RUN.
- RUN (one window per cycle, k = 0..NWIN-1):
  - Window operands: aw=a[4k+3:4k], bw=b[4k+3:4k].
  - Speculative carry-in spec_k: 0 for k=0; otherwise bit 4 of (a[4k-1:4k-4] + b[4k-1:4k-4]) with no carry-in.
  - Drive sum_block with A_i=aw, B_i=bw, Co_iprev=spec_k.
  - At the clock edge, store S_i into sum[4k+3:4k].
  - When k=NWIN-1, latch Co_i into cout and go to DONE. Otherwise k increments.
  - in_ready=0; in_valid is ignored.
- DONE:
  - out_valid=1; sum and cout are held stable.
  - On out_valid&&out_ready, go to IDLE and drop out_valid in the same edge.
- Latency and throughput:
  - Accept at edge T; out_valid is first high after edge T+NWIN.
  - No overlap between operations: one operation per NWIN+2 cycles minimum.
- Width rule: each window add is 4-bit + 4-bit + 1 giving 5 bits; bits above that are discarded.
- Boundary conditions:
  - out_ready held low: remain in DONE indefinitely with outputs stable.
  - out_ready high on entry to DONE: out_valid is high for exactly one cycle.
  - rst_n asserted mid-RUN or mid-DONE: immediately return to IDLE with all reset values. No partial result is emitted.
  - in_valid high in DONE: ignored, because in_ready=0.

Optional Feature:
SCSA_ERR_DETECT_EN
- Defined:
  - Keep an exact ripple-carry register c_exact, initialised to 0 at accept.
  - Each RUN cycle, compare spec_k with c_exact, then update c_exact to the true carry-out of aw+bw+c_exact.
  - err is sticky across RUN, valid together with out_valid, and cleared at the next accept.
  - At the last window, err also sets if the true carry-out differs from Co_i.
- Undefined: no err port and no exact-carry logic; err is absent from the port list.

Decomposition:
- Shared package scsa_pkg holds:
  - WIN_W=4.
  - State enum: IDLE, RUN, DONE.
  - A function spec_carry(aw, bw) returning bit 4 of aw+bw.
- One sub-module: the existing sum_block, instantiated once and shared by all windows.

Test Plan:
1. Reset: hold rst_n low 3 cycles, release -> in_ready=1, out_valid=0, sum=0x0000, cout=0, busy=0.
2. a=0x0001, b=0x0001 accepted at edge T -> out_valid after T+4, sum=0x0002, cout=0, err=0.
3. a=0x00FF, b=0x0001 -> sum=0x0000 (exact 0x0100), cout=0, err=1.
4. a=0xFFFF, b=0x0001 -> sum=0xFF00, cout=0 (exact 0x0000 with carry 1), err=1.
5. a=0x8000, b=0x8000 with out_ready low 3 cycles:
   - sum=0x0000, cout=1, err=0, all held.
   - in_valid pulses during the stall are ignored.
   - Handshake on cycle 4, then back to IDLE.
6. Assert rst_n during RUN with k=2 -> next cycle IDLE, outputs at reset values. A new a=0x1234, b=0x1111 -> sum=0x2345, cout=0.
